// File: rtl/circuito_uc_balanca.sv
// Control unit for the weighing/servo datapath: frame collection, window check,
// servo sweep 0..7 with one hold interval, and outcome reporting.
module circuito_uc_balanca #(
    parameter int FRAME_BYTES    = 12,
    parameter int TIMEOUT_CICLOS = 5_000_000,
    parameter int CNT_W          = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       fimRecepcao,
    input  logic       comando,
    input  logic       pesoMaxIgualZero,
    input  logic       perteceAoIntervalo,
    input  logic       fimContadorIntervalo,
    input  logic       inicioPosicao,
    input  logic       fimPosicao,
    output logic       enableReg,
    output logic       zeraUpdown,
    output logic       contaUpdown,
    output logic       zeraIntervalo,
    output logic       contaIntervalo,
    output logic       pronto,
    output logic       aceito,
    output logic       erro,
    output logic [3:0] db_estado
);
    localparam int TO_W = $clog2(TIMEOUT_CICLOS);
    localparam logic [CNT_W-1:0] FRAME_MAX = CNT_W'(FRAME_BYTES);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CICLOS - 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        ESPERA_BYTE = 4'h1,
        AVALIA      = 4'h2,
        PREPARA     = 4'h3,
        AVANCA      = 4'h4,
        SEGURA      = 4'h5,
        RETORNA     = 4'h6,
        REJEITA     = 4'h7,
        ERRO        = 4'h8,
        FIM         = 4'h9
    } state_t;

    state_t            r_estado;
    logic [CNT_W-1:0]  r_cnt;
    logic [TO_W-1:0]   r_timeout;
    logic              r_aceito;
    logic              r_erro;
    logic              w_espera;
    logic              w_zera;
    logic              w_unused;

    // The servo is always homed from the datapath side, so the home flag is informational only.
    assign w_unused = inicioPosicao;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado  <= INICIAL;
            r_cnt     <= '0;
            r_timeout <= '0;
            r_aceito  <= 1'b0;
            r_erro    <= 1'b0;
        end else begin
            case (r_estado)
                INICIAL: begin
                    if (iniciar) r_estado <= ESPERA_BYTE;
                end
                ESPERA_BYTE: begin
                    if (fimRecepcao) begin
                        if (comando) begin
                            r_estado <= (r_cnt == FRAME_MAX) ? AVALIA : ERRO;
                        end else if (r_cnt == FRAME_MAX) begin
                            r_estado <= ERRO;
                        end else begin
                            r_cnt     <= r_cnt + CNT_W'(1);
                            r_timeout <= '0;
                            if (r_cnt == '0) begin
                                r_aceito <= 1'b0;
                                r_erro   <= 1'b0;
                            end
                        end
                    end else if (r_cnt == '0) begin
                        r_timeout <= '0;
                    end else if (r_timeout == TO_LAST) begin
                        r_estado <= ERRO;
                    end else begin
                        r_timeout <= r_timeout + TO_W'(1);
                    end
                end
                AVALIA: begin
                    if (pesoMaxIgualZero)        r_estado <= ERRO;
                    else if (perteceAoIntervalo) r_estado <= PREPARA;
                    else                         r_estado <= REJEITA;
                end
                PREPARA: r_estado <= AVANCA;
                AVANCA: begin
                    if (fimContadorIntervalo && fimPosicao) r_estado <= SEGURA;
                end
                SEGURA: begin
                    if (fimContadorIntervalo) r_estado <= RETORNA;
                end
                RETORNA: begin
                    r_aceito <= 1'b1;
                    r_estado <= FIM;
                end
                REJEITA: begin
                    r_aceito <= 1'b0;
                    r_estado <= FIM;
                end
                ERRO: begin
                    r_erro   <= 1'b1;
                    r_aceito <= 1'b0;
                    r_estado <= FIM;
                end
                FIM: begin
                    r_cnt     <= '0;
                    r_timeout <= '0;
                    r_estado  <= ESPERA_BYTE;
                end
                default: r_estado <= INICIAL;
            endcase
        end
    end

    assign w_espera = (r_estado == ESPERA_BYTE);
    // Clear strobes are masked while reset is held so every output reads 0 during reset.
    assign w_zera   = reset && ((r_estado == INICIAL) || (r_estado == PREPARA) ||
                                (r_estado == RETORNA) || (r_estado == ERRO));

    assign enableReg      = w_espera && fimRecepcao && !comando && (r_cnt < FRAME_MAX);
    assign zeraUpdown     = w_zera;
    assign zeraIntervalo  = w_zera;
    assign contaIntervalo = (r_estado == AVANCA) || (r_estado == SEGURA);
    assign contaUpdown    = (r_estado == AVANCA) && fimContadorIntervalo && !fimPosicao;
    assign pronto         = (r_estado == FIM);
    assign aceito         = r_aceito;
    assign erro           = r_erro;
    assign db_estado      = r_estado;

endmodule
